// File: rtl/synth_pkg.sv
// Shared definitions for the voice allocator.
//   alloc_state_t  : allocator FSM states
//   MIDI_NOTE_W    : MIDI note number width
//   MIDI_VEL_W     : MIDI velocity width
//   FREQ_W_DEFAULT : default frequency word width (Hz*1000)
//   idx_w()        : width of an index that can address n voices
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2
  } alloc_state_t;

  localparam int MIDI_NOTE_W    = 7;
  localparam int MIDI_VEL_W     = 7;
  localparam int FREQ_W_DEFAULT = 24;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/midi_voice_slot.sv
// One oscillator slot: gate, note, frequency, velocity and age registers.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : take note_in/freq_in/vel_in, open gate, age 0
//   rel                 : close gate, keep note/freq/vel for the release tail
//   age_inc             : age+1 (saturating) if the gate is open
//   clear               : panic, close gate and zero age (highest priority)
//   note_in/freq_in/vel_in : values loaded on load
//   gate/note/freq/vel/age : current slot contents
module midi_voice_slot
  import synth_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEFAULT,
  parameter int AGE_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   rel,
  input  logic                   age_inc,
  input  logic                   clear,
  input  logic [MIDI_NOTE_W-1:0] note_in,
  input  logic [FREQ_W-1:0]      freq_in,
  input  logic [MIDI_VEL_W-1:0]  vel_in,
  output logic                   gate,
  output logic [MIDI_NOTE_W-1:0] note,
  output logic [FREQ_W-1:0]      freq,
  output logic [MIDI_VEL_W-1:0]  vel,
  output logic [AGE_W-1:0]       age
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate <= 1'b0;
      age  <= '0;
      note <= '0;
      freq <= '0;
      vel  <= '0;
    end else if (clear) begin
      gate <= 1'b0;
      age  <= '0;
    end else if (load) begin
      gate <= 1'b1;
      age  <= '0;
      note <= note_in;
      freq <= freq_in;
      vel  <= vel_in;
    end else if (rel) begin
      gate <= 1'b0;
    end else if (age_inc && gate && (age != AGE_MAX)) begin
      age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator. Takes one note event per handshake, scans the
// voice slots one per cycle, then retriggers / allocates / steals a slot on
// note-on or releases the matching slot on note-off.
// Ports:
//   CLK_50MHZ, RST_N    : clock, asynchronous active-low reset
//   ev_valid/ev_ready   : event handshake
//   ev_on/ev_note/ev_freq/ev_vel : event fields (vel 0 on note-on = note-off)
//   all_off             : panic, release every voice
//   voice_gate/note/freq/vel : per-voice registers, voice i in slice i
//   steal               : one-cycle pulse when a note-on took an active voice
module midi_voice_alloc
  import synth_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int FREQ_W = FREQ_W_DEFAULT,
  parameter int AGE_W  = 8
) (
  input  logic                          CLK_50MHZ,
  input  logic                          RST_N,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic                          ev_on,
  input  logic [MIDI_NOTE_W-1:0]        ev_note,
  input  logic [FREQ_W-1:0]             ev_freq,
  input  logic [MIDI_VEL_W-1:0]         ev_vel,
  input  logic                          all_off,
  output logic [VOICES-1:0]             voice_gate,
  output logic [MIDI_NOTE_W*VOICES-1:0] voice_note,
  output logic [FREQ_W*VOICES-1:0]      voice_freq,
  output logic [MIDI_VEL_W*VOICES-1:0]  voice_vel,
  output logic                          steal
);

  localparam int IW = idx_w(VOICES);
  localparam logic [IW-1:0] LAST_IDX = IW'(VOICES - 1);

  alloc_state_t state, state_n;
  logic [IW-1:0] idx;

  logic                   lat_on;
  logic [MIDI_NOTE_W-1:0] lat_note;
  logic [FREQ_W-1:0]      lat_freq;
  logic [MIDI_VEL_W-1:0]  lat_vel;

  logic          match_found, free_found, old_found;
  logic [IW-1:0] match_idx, free_idx, old_idx;
  logic [AGE_W-1:0] old_age;

  logic [VOICES-1:0] load, rel, age_inc;
  logic              clear, steal_n, accept;
  logic [IW-1:0]     target;

  logic [MIDI_NOTE_W-1:0] note_a [VOICES];
  logic [AGE_W-1:0]       age_a  [VOICES];

  assign ev_ready = (state == IDLE) && !all_off;
  assign accept   = ev_valid && ev_ready;

  // Event capture: fields are only looked at on the accept edge.
  always_ff @(posedge CLK_50MHZ) begin
    if (accept) begin
      lat_on   <= ev_on && (ev_vel != '0);
      lat_note <= ev_note;
      lat_freq <= ev_freq;
      lat_vel  <= ev_vel;
    end
  end

  // Control: FSM state, scan index, trackers, steal pulse.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      idx         <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
      steal       <= 1'b0;
    end else begin
      state <= state_n;
      steal <= steal_n;
      if (state != SCAN) begin
        idx         <= '0;
        match_found <= 1'b0;
        free_found  <= 1'b0;
        old_found   <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
        if (voice_gate[idx] && (note_a[idx] == lat_note) && !match_found) begin
          match_found <= 1'b1;
          match_idx   <= idx;
        end
        if (!voice_gate[idx] && !free_found) begin
          free_found <= 1'b1;
          free_idx   <= idx;
        end
        // Strictly greater keeps the lowest index on equal ages.
        if (voice_gate[idx] && (!old_found || (age_a[idx] > old_age))) begin
          old_found <= 1'b1;
          old_idx   <= idx;
          old_age   <= age_a[idx];
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    load    = '0;
    rel     = '0;
    age_inc = '0;
    clear   = 1'b0;
    steal_n = 1'b0;
    target  = '0;
    case (state)
      IDLE: if (accept) state_n = SCAN;
      SCAN: if (idx == LAST_IDX) state_n = APPLY;
      APPLY: begin
        state_n = IDLE;
        if (lat_on) begin
          if (match_found)     target = match_idx;
          else if (free_found) target = free_idx;
          else begin
            target  = old_idx;
            steal_n = 1'b1;
          end
          for (int i = 0; i < VOICES; i++) begin
            if (IW'(i) == target) load[i] = 1'b1;
            else                  age_inc[i] = 1'b1;
          end
        end else if (match_found) begin
          for (int i = 0; i < VOICES; i++)
            if (IW'(i) == match_idx) rel[i] = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Panic wins over everything, including a pending APPLY.
    if (all_off) begin
      state_n = IDLE;
      load    = '0;
      rel     = '0;
      age_inc = '0;
      clear   = 1'b1;
      steal_n = 1'b0;
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_slot
    midi_voice_slot #(
      .FREQ_W(FREQ_W),
      .AGE_W (AGE_W)
    ) u_slot (
      .clk    (CLK_50MHZ),
      .rst_n  (RST_N),
      .load   (load[g]),
      .rel    (rel[g]),
      .age_inc(age_inc[g]),
      .clear  (clear),
      .note_in(lat_note),
      .freq_in(lat_freq),
      .vel_in (lat_vel),
      .gate   (voice_gate[g]),
      .note   (note_a[g]),
      .freq   (voice_freq[g*FREQ_W +: FREQ_W]),
      .vel    (voice_vel[g*MIDI_VEL_W +: MIDI_VEL_W]),
      .age    (age_a[g])
    );
    assign voice_note[g*MIDI_NOTE_W +: MIDI_NOTE_W] = note_a[g];
  end

endmodule

// File: tb/tb_midi_voice_alloc.sv
module tb_midi_voice_alloc;

  localparam int V  = 4;
  localparam int FW = 24;
  localparam int AW = 8;
  localparam int AGE_MAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_ready;
  logic          ev_on = 1'b0;
  logic [6:0]    ev_note = '0;
  logic [FW-1:0] ev_freq = '0;
  logic [6:0]    ev_vel = '0;
  logic          all_off = 1'b0;
  logic [V-1:0]  voice_gate;
  logic [7*V-1:0]  voice_note;
  logic [FW*V-1:0] voice_freq;
  logic [7*V-1:0]  voice_vel;
  logic          steal;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_gate [V];
  int          m_note [V];
  int          m_freq [V];
  int          m_vel  [V];
  int          m_age  [V];

  always #10 clk = ~clk;

  midi_voice_alloc #(.VOICES(V), .FREQ_W(FW), .AGE_W(AW)) dut (
    .CLK_50MHZ (clk),
    .RST_N     (rst_n),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_on     (ev_on),
    .ev_note   (ev_note),
    .ev_freq   (ev_freq),
    .ev_vel    (ev_vel),
    .all_off   (all_off),
    .voice_gate(voice_gate),
    .voice_note(voice_note),
    .voice_freq(voice_freq),
    .voice_vel (voice_vel),
    .steal     (steal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] freq_of(input int n);
    return FW'(n * 1000 + 440);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < V; i++) begin
      m_gate[i] = 0; m_note[i] = 0; m_freq[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
  endfunction

  function automatic void model_panic();
    for (int i = 0; i < V; i++) begin
      m_gate[i] = 0; m_age[i] = 0;
    end
  endfunction

  // Allocation rules: retrigger the held note, else lowest free voice,
  // else the longest-held voice (lowest index on a tie).
  function automatic bit model_event(input bit on, input int n, input int f, input int v);
    int m = -1, fr = -1, o = -1, oa = -1, t;
    bit st = 0;
    for (int i = 0; i < V; i++) begin
      if (m_gate[i] && m_note[i] == n && m < 0) m = i;
      if (!m_gate[i] && fr < 0) fr = i;
      if (m_gate[i] && m_age[i] > oa) begin o = i; oa = m_age[i]; end
    end
    if (on && v != 0) begin
      if (m >= 0) t = m;
      else if (fr >= 0) t = fr;
      else begin t = o; st = 1; end
      for (int i = 0; i < V; i++) begin
        if (i == t) begin
          m_gate[i] = 1; m_note[i] = n; m_freq[i] = f; m_vel[i] = v; m_age[i] = 0;
        end else if (m_gate[i] && m_age[i] < AGE_MAX) begin
          m_age[i]++;
        end
      end
    end else if (m >= 0) begin
      m_gate[m] = 0;
    end
    return st;
  endfunction

  task automatic check_voices(input string tag);
    for (int i = 0; i < V; i++) begin
      chk($sformatf("%s_gate%0d", tag, i), 32'(voice_gate[i]), 32'(m_gate[i]));
      chk($sformatf("%s_note%0d", tag, i), 32'(voice_note[7*i +: 7]), 32'(m_note[i]));
      chk($sformatf("%s_freq%0d", tag, i), 32'(voice_freq[FW*i +: FW]), 32'(m_freq[i]));
      chk($sformatf("%s_vel%0d", tag, i), 32'(voice_vel[7*i +: 7]), 32'(m_vel[i]));
    end
  endtask

  // Called just after a falling edge; returns there too.
  task automatic do_event(input string tag, input bit on, input int n, input int v);
    int w = 0;
    bit st;
    while (!ev_ready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) chk({tag, "_ready_timeout"}, 32'(ev_ready), 32'd1);
    ev_valid = 1'b1; ev_on = on; ev_note = 7'(n); ev_freq = freq_of(n); ev_vel = 7'(v);
    @(posedge clk);
    @(negedge clk);
    // Scramble the fields: they must be ignored after the accept edge.
    ev_valid = 1'b0; ev_on = 1'($urandom); ev_note = 7'($urandom);
    ev_freq = FW'($urandom); ev_vel = 7'($urandom);
    chk({tag, "_busy"}, 32'(ev_ready), 32'd0);
    for (int c = 1; c <= V; c++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(ev_ready), 32'd0);
    end
    st = model_event(on, n, int'(freq_of(n)), v);
    @(negedge clk);
    chk({tag, "_ready_back"}, 32'(ev_ready), 32'd1);
    chk({tag, "_steal"}, 32'(steal), 32'(st));
    check_voices(tag);
    @(negedge clk);
    chk({tag, "_steal_end"}, 32'(steal), 32'd0);
  endtask

  initial begin
    model_reset();
    // Reset state
    #1;
    chk("rst_ready", 32'(ev_ready), 32'd1);
    chk("rst_gate", 32'(voice_gate), 32'd0);
    chk("rst_steal", 32'(steal), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_voices("rst");

    // Fill four voices in order
    do_event("fill0", 1, 60, 100);
    do_event("fill1", 1, 62, 100);
    do_event("fill2", 1, 64, 100);
    do_event("fill3", 1, 65, 100);
    chk("fill_gates", 32'(voice_gate), 32'hF);
    chk("fill_note3", 32'(voice_note[21 +: 7]), 32'd65);

    // Fifth note steals voice 0, the oldest
    do_event("steal", 1, 67, 100);
    chk("steal_note0", 32'(voice_note[0 +: 7]), 32'd67);

    // Retrigger 62 on voice 1, then release it, then an unheld note-off
    do_event("retrig", 1, 62, 90);
    chk("retrig_vel1", 32'(voice_vel[7 +: 7]), 32'd90);
    do_event("off62", 0, 62, 40);
    chk("off62_gate1", 32'(voice_gate[1]), 32'd0);
    chk("off62_freq1", 32'(voice_freq[FW +: FW]), 32'(freq_of(62)));
    do_event("off70", 0, 70, 40);

    // Note-on with velocity zero behaves as note-off
    do_event("vel0", 1, 64, 0);
    chk("vel0_gate2", 32'(voice_gate[2]), 32'd0);

    // Voice 1 is free now; with 2 free, a new note lands at lowest free (1)
    do_event("refill", 1, 71, 55);
    chk("refill_note1", 32'(voice_note[7 +: 7]), 32'd71);

    // Panic during the scan of a note-on
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd72; ev_freq = freq_of(72); ev_vel = 7'd80;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    all_off = 1'b1;
    #1;
    chk("panic_ready_low", 32'(ev_ready), 32'd0);
    @(negedge clk);
    model_panic();
    chk("panic_ready_held", 32'(ev_ready), 32'd0);
    check_voices("panic");
    all_off = 1'b0;
    #1;
    chk("panic_ready_back", 32'(ev_ready), 32'd1);
    repeat (V + 3) begin
      @(negedge clk);
      chk("panic_steal", 32'(steal), 32'd0);
    end
    check_voices("panic_after");

    // Randomised events over a narrow note range so matches and steals are frequent
    for (int k = 0; k < 40; k++) begin
      int n, v;
      bit on;
      n  = 60 + int'($urandom_range(0, 7));
      on = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
      do_event($sformatf("rnd%0d", k), on, n, v);
    end

    // Reset asserted mid-scan
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd50; ev_freq = freq_of(50); ev_vel = 7'd33;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_ready", 32'(ev_ready), 32'd1);
    chk("midrst_steal", 32'(steal), 32'd0);
    check_voices("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (V + 2) @(negedge clk);
    check_voices("midrst_after");
    do_event("post_rst", 1, 48, 77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
